ram_arbiter: RTL

- Shares the single-port 64K main RAM between three requesters: the CPU, the video text-mode fetcher and the SD-card DMA engine.
- Sits between the address decoder's RAM chip-select path and the RAM instance.
- Stalls the CPU through the T65 Rdy input while the RAM is busy.
- Returns read data through per-requester holding registers with valid strobes.

---
 rtl/ram_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between CPU, video fetcher and DMA: grant in N, RAM access in N+1, read data valid in N+3.
// Backpressure: CPU stalled via cpu_rdy_o; video/DMA hold their request until ack; CPU forced through after CPU_MAX_WAIT refusals.
module ram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_rdy_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic              vid_ack_o,
    output logic              vid_valid_o,
    output logic [DATA_W-1:0] vid_rdata_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_ack_o,
    output logic              dma_valid_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [1:0]        grant_o
);

    localparam int WCNT_W = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(CPU_MAX_WAIT);

    typedef enum logic [2:0] {C_IDLE, C_WAIT, C_ISSUE, C_READ, C_DONE} cpu_state_e;
    typedef enum logic [1:0] {G_NONE = 2'd0, G_CPU = 2'd1, G_VID = 2'd2, G_DMA = 2'd3} grant_e;

    cpu_state_e        state_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              cpu_we_q;
    logic              cpu_rdy_q;
    logic              rr_dma_q;

    grant_e            win_d;
    logic              cpu_elig;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              ram_cs_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    grant_e            grant_q;
    grant_e            rd1_q;
    grant_e            rd2_q;
    logic              vid_valid_q;
    logic              dma_valid_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    assign cpu_elig = cpu_req_i && (state_q == C_IDLE || state_q == C_WAIT);

    always_comb begin
        win_d = G_NONE;
        if (!rst_n_i) begin
            win_d = G_NONE;
        end else if (cpu_elig && wcnt_q == WAIT_MAX) begin
            win_d = G_CPU;
        end else if (vid_req_i) begin
            win_d = G_VID;
        end else if (cpu_elig && dma_req_i) begin
            win_d = rr_dma_q ? G_DMA : G_CPU;
        end else if (cpu_elig) begin
            win_d = G_CPU;
        end else if (dma_req_i) begin
            win_d = G_DMA;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = cpu_addr_i;
        sel_wdata = cpu_wdata_i;
        case (win_d)
            G_CPU: sel_we = cpu_we_i;
            G_VID: sel_addr = vid_addr_i;
            G_DMA: begin
                sel_we    = dma_we_i;
                sel_addr  = dma_addr_i;
                sel_wdata = dma_wdata_i;
            end
            default: ;
        endcase
    end

    assign vid_ack_o = (win_d == G_VID);
    assign dma_ack_o = (win_d == G_DMA);

    // rd1/rd2 track which requester owns the read in flight, so completions follow grant order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            grant_q     <= G_NONE;
            rd1_q       <= G_NONE;
            rd2_q       <= G_NONE;
            vid_valid_q <= 1'b0;
            dma_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            dma_rdata_q <= '0;
            rr_dma_q    <= 1'b0;
        end else begin
            ram_cs_q    <= (win_d != G_NONE);
            ram_we_q    <= sel_we;
            ram_addr_q  <= sel_addr;
            ram_wdata_q <= sel_wdata;
            grant_q     <= win_d;
            rd1_q       <= (win_d != G_NONE && !sel_we) ? win_d : G_NONE;
            rd2_q       <= rd1_q;
            vid_valid_q <= (rd2_q == G_VID);
            dma_valid_q <= (rd2_q == G_DMA);
            if (rd2_q == G_CPU) cpu_rdata_q <= ram_rdata_i;
            if (rd2_q == G_VID) vid_rdata_q <= ram_rdata_i;
            if (rd2_q == G_DMA) dma_rdata_q <= ram_rdata_i;
            if (win_d == G_CPU) begin
                rr_dma_q <= 1'b1;
            end else if (win_d == G_DMA) begin
                rr_dma_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= C_IDLE;
            wcnt_q    <= '0;
            cpu_we_q  <= 1'b0;
            cpu_rdy_q <= 1'b1;
        end else begin
            case (state_q)
                C_IDLE, C_WAIT: begin
                    if (win_d == G_CPU) begin
                        state_q   <= C_ISSUE;
                        cpu_we_q  <= cpu_we_i;
                        cpu_rdy_q <= cpu_we_i;
                        wcnt_q    <= '0;
                    end else if (cpu_req_i) begin
                        state_q <= C_WAIT;
                        if (wcnt_q != WAIT_MAX) wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                C_ISSUE: begin
                    state_q   <= cpu_we_q ? C_IDLE : C_READ;
                    cpu_rdy_q <= 1'b0;
                end
                C_READ: begin
                    state_q   <= C_DONE;
                    cpu_rdy_q <= 1'b1;
                end
                C_DONE:  state_q <= C_IDLE;
                default: state_q <= C_IDLE;
            endcase
        end
    end

    assign cpu_rdy_o   = !rst_n_i ||
                         ((state_q == C_IDLE || state_q == C_WAIT) ? !cpu_req_i : cpu_rdy_q);
    assign cpu_rdata_o = cpu_rdata_q;
    assign vid_valid_o = vid_valid_q;
    assign vid_rdata_o = vid_rdata_q;
    assign dma_valid_o = dma_valid_q;
    assign dma_rdata_o = dma_rdata_q;
    assign ram_cs_o    = ram_cs_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign grant_o     = grant_q;

endmodule
